// File: rtl/load_store_unit.sv
// MEM-stage load/store controller: byte/half/word accesses mapped onto a
// word-organised data memory, with read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rdata,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data
);

  typedef enum logic [2:0] {
    IDLE, RD, LATCH, WR, RESP
  } state_t;

  localparam logic [29:0] LIMIT = 30'(MEM_WORDS);

  state_t      state_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        valid_q;
  logic        fault_q;
  logic [31:0] rdata_q;
  logic [31:0] maddr_q;
  logic        rd_en_q;
  logic        wr_en_q;
  logic [31:0] wr_data_q;

  logic        accept;
  logic        req_bad;
  logic [4:0]  sh;
  logic [31:0] lane;
  logic [31:0] ext;
  logic [31:0] mask;
  logic [31:0] merged;

  assign req_ready   = (state_q == IDLE) && !rst;
  assign accept      = req_valid && req_ready;
  assign resp_valid  = valid_q;
  assign resp_fault  = fault_q;
  assign resp_rdata  = rdata_q;
  assign mem_addr    = maddr_q;
  assign mem_rd_en   = rd_en_q;
  // A reset landing in WR must suppress the commit on that same edge.
  assign mem_wr_en   = wr_en_q && !rst;
  assign mem_wr_data = wr_data_q;

  always_comb begin
    req_bad = 1'b0;
    unique case (req_size)
      2'b00:   req_bad = 1'b0;
      2'b01:   req_bad = req_addr[0];
      2'b10:   req_bad = (req_addr[1:0] != 2'b00);
      default: req_bad = 1'b1;
    endcase
    if (req_addr[31:2] >= LIMIT) req_bad = 1'b1;
  end

  always_comb begin
    sh   = {addr_q[1:0], 3'b000};
    lane = mem_rdata >> sh;
    ext  = mem_rdata;
    mask = 32'hFFFF << sh;
    unique case (size_q)
      2'b00: begin
        ext  = {{24{sgn_q & lane[7]}}, lane[7:0]};
        mask = 32'h0000_00FF << sh;
      end
      2'b01: ext = {{16{sgn_q & lane[15]}}, lane[15:0]};
      default: ext = mem_rdata;
    endcase
    merged = (mem_rdata & ~mask) | ((wdata_q << sh) & mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      sgn_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      rdata_q   <= '0;
      maddr_q   <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      valid_q <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            sgn_q   <= req_signed;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            maddr_q <= {2'b00, req_addr[31:2]};
            if (req_bad) begin
              state_q <= RESP;
              valid_q <= 1'b1;
              fault_q <= 1'b1;
              rdata_q <= '0;
            end else if (req_we && req_size == 2'b10) begin
              state_q   <= WR;
              wr_en_q   <= 1'b1;
              wr_data_q <= req_wdata;
            end else begin
              state_q <= RD;
              rd_en_q <= 1'b1;
            end
          end
        end
        RD: state_q <= LATCH;
        LATCH: begin
          if (we_q) begin
            state_q   <= WR;
            wr_en_q   <= 1'b1;
            wr_data_q <= merged;
          end else begin
            state_q <= RESP;
            valid_q <= 1'b1;
            fault_q <= 1'b0;
            rdata_q <= ext;
          end
        end
        WR: begin
          state_q <= RESP;
          valid_q <= 1'b1;
          fault_q <= 1'b0;
          rdata_q <= '0;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver queues expected responses,
// a negedge monitor pairs them with accepts and responses.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;

  load_store_unit #(.MEM_WORDS(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [32];

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr[4:0]] <= mem_wr_data;
    if (mem_rd_en) mem_rdata <= mem[mem_addr[4:0]];
  end

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  int   acc_cnt = 0;
  logic prev_rd = 1'b0;
  logic [31:0] last_wr_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    nchk++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid && req_ready) begin
        acc_q.push_back(cyc);
        acc_cnt++;
      end
      if (mem_rd_en || mem_wr_en || resp_valid)
        chk("ready_low_busy", 32'(req_ready), 32'd0);
      if (mem_rd_en) begin
        rd_cnt++;
        chk("rd_wr_excl", 32'(mem_wr_en), 32'd0);
        chk("rd_gap", 32'(prev_rd), 32'd0);
      end
      if (mem_wr_en) begin
        wr_cnt++;
        last_wr_addr = mem_addr;
      end
      if (resp_valid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          int   a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_fault", 32'(resp_fault), 32'(e.fault));
          chk("resp_latency", 32'(cyc - a), 32'(e.lat));
        end
      end
    end
    prev_rd = mem_rd_en;
  end

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("resp_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      acc_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic we, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er,
                       input logic ef, input int lat);
    int n = 0;
    exp_t e;
    e.rdata = er;
    e.fault = ef;
    e.lat   = lat;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  int rd0;
  int wr0;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'b00;
    req_signed = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0101_0101 * i;
    mem[0] = 32'h0BAD_F00D;
    mem[1] = 32'h5566_7788;
    mem[3] = 32'hCAFE_1234;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_fault", 32'(resp_fault), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wr_data, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 32'd1);

    issue(1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 32'h0, 0, 2);
    drain();
    chk("sw_mem2", mem[2], 32'hDEADBEEF);
    chk("sw_addr", last_wr_addr, 32'd2);
    issue(0, 2'b10, 0, 32'h08, 32'h0, 32'hDEADBEEF, 0, 3);
    drain();

    mem[2] = 32'h1122_3344;
    issue(1, 2'b00, 0, 32'h09, 32'h0000_00AA, 32'h0, 0, 4);
    drain();
    chk("sb_mem2", mem[2], 32'h1122_AA44);
    issue(0, 2'b00, 1, 32'h09, 32'h0, 32'hFFFF_FFAA, 0, 3);
    issue(0, 2'b00, 0, 32'h09, 32'h0, 32'h0000_00AA, 0, 3);
    issue(0, 2'b00, 1, 32'h0A, 32'h0, 32'h0000_0022, 0, 3);
    drain();

    issue(1, 2'b01, 0, 32'h0E, 32'h0000_8001, 32'h0, 0, 4);
    drain();
    chk("sh_mem3", mem[3], 32'h8001_1234);
    issue(0, 2'b01, 1, 32'h0E, 32'h0, 32'hFFFF_8001, 0, 3);
    issue(0, 2'b01, 0, 32'h0C, 32'h0, 32'h0000_1234, 0, 3);
    drain();

    rd0 = rd_cnt;
    wr0 = wr_cnt;
    issue(0, 2'b10, 0, 32'h06, 32'h0, 32'h0, 1, 1);
    issue(1, 2'b01, 0, 32'h03, 32'h1234, 32'h0, 1, 1);
    issue(0, 2'b11, 0, 32'h00, 32'h0, 32'h0, 1, 1);
    issue(0, 2'b10, 0, 32'h80, 32'h0, 32'h0, 1, 1);
    drain();
    chk("fault_no_rd", 32'(rd_cnt - rd0), 32'd0);
    chk("fault_no_wr", 32'(wr_cnt - wr0), 32'd0);

    // Reset asserted during LATCH of a byte store.
    wr0 = wr_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_size = 2'b00;
    req_addr = 32'h04;
    req_wdata = 32'h99;
    @(negedge clk);
    chk("rst_test_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    acc_q.delete();
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    repeat (6) @(negedge clk);
    chk("rst_no_wr", 32'(wr_cnt - wr0), 32'd0);
    chk("rst_mem1", mem[1], 32'h5566_7788);

    rd0 = rd_cnt;
    begin
      exp_t e;
      int   n;
      int   a0;
      e.rdata = 32'h0BAD_F00D;
      e.fault = 1'b0;
      e.lat   = 3;
      exp_q.push_back(e);
      exp_q.push_back(e);
      a0 = acc_cnt;
      n = 0;
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_we = 1'b0;
      req_size = 2'b10;
      req_addr = 32'h00;
      while (acc_cnt - a0 < 2 && n < 30) begin
        @(posedge clk);
        #1;
        n++;
      end
      req_valid = 1'b0;
      chk("b2b_accepts", 32'(acc_cnt - a0), 32'd2);
    end
    drain();
    chk("b2b_rd_pulses", 32'(rd_cnt - rd0), 32'd2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
